// File: rtl/fft_pkg.sv
// Shared definitions for the Biplex FFT datapath blocks: fill-FSM state
// encoding, the default sample width and an address-width helper.
package fft_pkg;

    localparam int FFT_DATA_W = 18;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } fill_state_e;

    // Address bits needed to index a memory of the given depth (at least 1).
    function automatic int addr_w_for(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port block RAM: one write port, one read port, read-first on
// an address collision, registered read data that holds while rd_en is low.
// No reset, so it maps directly onto a block RAM primitive.
module sdp_ram
    import fft_pkg::*;
#(
    parameter int WIDTH = FFT_DATA_W,
    parameter int DEPTH = 512,
    localparam int AW   = addr_w_for(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read returns the pre-write contents when both ports hit the same word.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/delay_bram.sv
// Enable-gated sample delay line on a circular-addressed block RAM.
// Each accepted sample reappears exactly DELAY accepted samples later.
// A fill FSM keeps stale RAM contents from ever being flagged valid.
//
// Optional build macro DELAY_BRAM_SYNC_EN: carries a 1-bit sync marker
// alongside each sample (sync_in / sync_out), widening the RAM by one bit.
//
// state | meaning
// ------+---------------------------------------------------------------
// FILL  | fewer than DELAY samples accepted since reset; output not valid
// RUN   | delay line primed; every accepted sample yields a valid output
module delay_bram
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int ADDR_W = 9,
    parameter int DELAY  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_en,
    input  logic [DATA_W-1:0] in_data,
`ifdef DELAY_BRAM_SYNC_EN
    input  logic              sync_in,
    output logic              sync_out,
`endif
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              filled
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef DELAY_BRAM_SYNC_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    localparam logic [ADDR_W-1:0] WA_LAST   = ADDR_W'(DELAY - 1);
    localparam logic [ADDR_W:0]   FILL_LAST = (ADDR_W + 1)'(DELAY - 1);
    localparam logic [0:0]        ST_FILL   = FILL;
    localparam logic [0:0]        ST_RUN    = RUN;

    logic [ADDR_W-1:0] wa;
    logic [ADDR_W:0]   fill_cnt;
    logic [0:0]        state;
    logic              rd_live;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram_rdata;

`ifdef DELAY_BRAM_SYNC_EN
    assign ram_wdata = {sync_in, in_data};
`else
    assign ram_wdata = in_data;
`endif

    // Shared read/write address; wraps after DELAY-1 so the word read back
    // is the one written DELAY enables earlier.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wa <= '0;
        end else if (in_en) begin
            wa <= (wa == WA_LAST) ? '0 : wa + ADDR_W'(1);
        end
    end

    // Fill FSM: count accepted samples until the line is primed, then stay in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_FILL;
            fill_cnt <= '0;
        end else if (in_en && state == ST_FILL) begin
            fill_cnt <= fill_cnt + (ADDR_W + 1)'(1);
            if (fill_cnt == FILL_LAST) begin
                state <= ST_RUN;
            end
        end
    end

    // Output strobe and read-data gate; the gate keeps out_data at zero from
    // reset until the RAM output register has been loaded at least once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            rd_live   <= 1'b0;
        end else begin
            out_valid <= in_en && (state == ST_RUN);
            if (in_en) begin
                rd_live <= 1'b1;
            end
        end
    end

    sdp_ram #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (in_en),
        .wr_addr (wa),
        .wr_data (ram_wdata),
        .rd_en   (in_en),
        .rd_addr (wa),
        .rd_data (ram_rdata)
    );

    assign out_data = rd_live ? ram_rdata[DATA_W-1:0] : '0;
    assign filled   = (state == ST_RUN);

`ifdef DELAY_BRAM_SYNC_EN
    assign sync_out = out_valid & ram_rdata[DATA_W];
`endif

endmodule

// File: tb/tb_delay_bram.sv
// Bench for delay_bram: two instances (DELAY=4 and DELAY=8 at ADDR_W=3) see
// the same stimulus and are compared against a sample-index reference model.
module tb_delay_bram;

    localparam int DW = 18;
    localparam int AW = 3;
    localparam int D0 = 4;
    localparam int D1 = 8;
    localparam int HIST = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_en = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic sync_in = 1'b0;

    logic v0, f0, v1, f1;
    logic [DW-1:0] d0, d1;
`ifdef DELAY_BRAM_SYNC_EN
    logic s0, s1;
`endif

    always #5 clk = ~clk;

    delay_bram #(.DATA_W(DW), .ADDR_W(AW), .DELAY(D0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_en     (in_en),
        .in_data   (in_data),
`ifdef DELAY_BRAM_SYNC_EN
        .sync_in   (sync_in),
        .sync_out  (s0),
`endif
        .out_valid (v0),
        .out_data  (d0),
        .filled    (f0)
    );

    delay_bram #(.DATA_W(DW), .ADDR_W(AW), .DELAY(D1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_en     (in_en),
        .in_data   (in_data),
`ifdef DELAY_BRAM_SYNC_EN
        .sync_in   (sync_in),
        .sync_out  (s1),
`endif
        .out_valid (v1),
        .out_data  (d1),
        .filled    (f1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: samples accepted since reset, per instance.
    logic [DW:0]   hist [2][HIST];
    int            cnt [2];
    int            dl [2] = '{D0, D1};
    int            known [2];   // 0: zero after reset, 1: undefined fill data, 2: held valid sample
    logic [DW-1:0] held [2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            cnt[k]   = 0;
            known[k] = 0;
            held[k]  = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b0;
        in_en = 1'b0;
        #1;
        chk("rst valid0",  32'(v0), 32'd0);
        chk("rst filled0", 32'(f0), 32'd0);
        chk("rst data0",   32'(d0), 32'd0);
        chk("rst valid1",  32'(v1), 32'd0);
        chk("rst filled1", 32'(f1), 32'd0);
        chk("rst data1",   32'(d1), 32'd0);
`ifdef DELAY_BRAM_SYNC_EN
        chk("rst sync0", 32'(s0), 32'd0);
        chk("rst sync1", 32'(s1), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic step(input logic en, input logic [DW-1:0] d, input logic s);
        logic          exp_v, exp_s, act_v, act_f;
        logic [DW-1:0] act_d;
        int            idx;
        @(negedge clk);
        in_en   = en;
        in_data = d;
        sync_in = s;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_v = 1'b0;
            exp_s = 1'b0;
            if (en) begin
                idx = cnt[k];
                if (idx < HIST) hist[k][idx] = {s, d};
                cnt[k]++;
                if (idx >= dl[k] && idx < HIST) begin
                    exp_v    = 1'b1;
                    held[k]  = hist[k][idx - dl[k]][DW-1:0];
                    exp_s    = hist[k][idx - dl[k]][DW];
                    known[k] = 2;
                end else begin
                    known[k] = 1;
                end
            end
            act_v = (k == 0) ? v0 : v1;
            act_f = (k == 0) ? f0 : f1;
            act_d = (k == 0) ? d0 : d1;
            chk($sformatf("dut%0d out_valid", k), 32'(act_v), 32'(exp_v));
            chk($sformatf("dut%0d filled", k), 32'(act_f), 32'(cnt[k] >= dl[k]));
            if (known[k] != 1) begin
                chk($sformatf("dut%0d out_data", k), 32'(act_d), 32'(held[k]));
            end
`ifdef DELAY_BRAM_SYNC_EN
            chk($sformatf("dut%0d sync_out", k), 32'((k == 0) ? s0 : s1), 32'(exp_s));
`endif
        end
    endtask

    initial begin
        model_reset();
        do_reset();

        // continuous enable, sync marker on sample 3
        for (int i = 1; i <= 14; i++) step(1'b1, DW'(i), i == 3);

        // gapped enable every third cycle, data changes during gaps
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, DW'(10 * i), 1'b0);
            step(1'b0, DW'($urandom), 1'b0);
            step(1'b0, DW'($urandom), 1'b0);
        end

        // reset mid-run, then refill from 100
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, DW'(200 + i), 1'b0);
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, DW'(100 + i), 1'b0);

        // address wrap on the DELAY = 2**ADDR_W instance
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, DW'(i), 1'b0);

        // randomized enables, data and sync, with one reset partway
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step($urandom_range(0, 2) != 0, DW'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
